icache_dm: RTL

//  Direct-mapped instruction cache directly upstream of the IF stage. Serves

---
 rtl/icache_dm_pkg.sv | 31 +++
 rtl/icache_dm_if.sv | 37 +++
 rtl/icache_dm_array.sv | 47 ++++
 rtl/icache_dm.sv | 108 ++++++++++
 4 files changed

// File: rtl/icache_dm_pkg.sv
// Shared types for the direct-mapped instruction cache: bus command encoding,
// memory tag width, cache entry layout and controller state.
package icache_dm_pkg;

  localparam int XLEN      = 32;
  localparam int MEM_TAG_W = 4;
  // Widest stored tag (CACHE_LINES=2); narrower configurations zero-extend.
  localparam int ICACHE_TAG_W = XLEN - 4;

  typedef enum logic [1:0] {
    BUS_NONE = 2'd0,
    BUS_LOAD = 2'd1
  } bus_cmd_e;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [63:0]             data;
  } ICACHE_ENTRY;

  typedef enum logic {
    ICACHE_IDLE = 1'b0,
    ICACHE_WAIT = 1'b1
  } ICACHE_STATE;

  // Align a fetch address down to its 8-byte line.
  function automatic logic [XLEN-1:0] line_addr(input logic [XLEN-1:0] a);
    return {a[XLEN-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// Optional macro ICACHE_STATS_EN adds the hit/miss counter outputs.
interface icache_dm_if;
  import icache_dm_pkg::*;

  logic [XLEN-1:0]      proc2Icache_addr;
  logic [MEM_TAG_W-1:0] Imem2proc_response;
  logic [63:0]          Imem2proc_data;
  logic [MEM_TAG_W-1:0] Imem2proc_tag;
  bus_cmd_e             proc2Imem_command;
  logic [XLEN-1:0]      proc2Imem_addr;
  logic [63:0]          Icache_data_out;
  logic                 Icache_valid_out;
`ifdef ICACHE_STATS_EN
  logic [31:0]          icache_hit_cnt;
  logic [31:0]          icache_miss_cnt;
`endif

  // Cache side.
  modport slave (
    input  proc2Icache_addr, Imem2proc_response, Imem2proc_data, Imem2proc_tag,
    output proc2Imem_command, proc2Imem_addr, Icache_data_out, Icache_valid_out
`ifdef ICACHE_STATS_EN
    , output icache_hit_cnt, icache_miss_cnt
`endif
  );

  // Fetch stage / memory side.
  modport master (
    output proc2Icache_addr, Imem2proc_response, Imem2proc_data, Imem2proc_tag,
    input  proc2Imem_command, proc2Imem_addr, Icache_data_out, Icache_valid_out
`ifdef ICACHE_STATS_EN
    , input icache_hit_cnt, icache_miss_cnt
`endif
  );

endinterface

// File: rtl/icache_dm_array.sv
// icache_array: CACHE_LINES entries of {valid, tag, data}. Combinational read
// by index, one synchronous write per cycle, valid bits cleared on reset.
module icache_dm_array
  import icache_dm_pkg::*;
#(
  parameter int CACHE_LINES = 32,
  parameter int IDX_BITS    = $clog2(CACHE_LINES)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [IDX_BITS-1:0]     rd_idx,
  output ICACHE_ENTRY             rd_entry,
  input  logic                    wr_en,
  input  logic [IDX_BITS-1:0]     wr_idx,
  input  logic [ICACHE_TAG_W-1:0] wr_tag,
  input  logic [63:0]             wr_data
);

  logic [CACHE_LINES-1:0]  valid_q;
  logic [ICACHE_TAG_W-1:0] tag_q  [CACHE_LINES];
  logic [63:0]             data_q [CACHE_LINES];

  // Valid bits: cleared by reset, set by a fill.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  // Combinational read of the indexed entry.
  always_comb begin
    rd_entry.valid = valid_q[rd_idx];
    rd_entry.tag   = tag_q[rd_idx];
    rd_entry.data  = data_q[rd_idx];
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache in front of IF. Hits return the line in the
// same cycle; a miss issues one tagged BUS_LOAD and fills when the tag returns.
// Optional macro ICACHE_STATS_EN adds wrapping 32-bit hit/miss counters.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int CACHE_LINES = 32
) (
  input  logic        clock,
  input  logic        reset,
  icache_dm_if.slave  bus
);

  localparam int IDX_BITS = $clog2(CACHE_LINES);
  localparam int TAG_BITS = XLEN - 3 - IDX_BITS;

  ICACHE_STATE          state;
  logic [MEM_TAG_W-1:0] pending_tag;
  logic [XLEN-1:0]      pending_addr;

  logic [IDX_BITS-1:0]  idx;
  logic [TAG_BITS-1:0]  tag;
  ICACHE_ENTRY          rd_entry;
  logic                 hit;
  logic                 miss_load;
  logic                 accept;
  logic                 fill;
  logic                 unused_low_bits;

  assign idx = bus.proc2Icache_addr[IDX_BITS+2:3];
  assign tag = bus.proc2Icache_addr[XLEN-1:IDX_BITS+3];

  assign unused_low_bits = ^{bus.proc2Icache_addr[2:0], pending_addr[2:0]};

  icache_dm_array #(
    .CACHE_LINES (CACHE_LINES),
    .IDX_BITS    (IDX_BITS)
  ) u_array (
    .clock    (clock),
    .reset    (reset),
    .rd_idx   (idx),
    .rd_entry (rd_entry),
    .wr_en    (fill),
    .wr_idx   (pending_addr[IDX_BITS+2:3]),
    .wr_tag   (ICACHE_TAG_W'(pending_addr[XLEN-1:IDX_BITS+3])),
    .wr_data  (bus.Imem2proc_data)
  );

  // Lookup and request decode; the fill only lands next cycle (no bypass).
  always_comb begin
    hit       = !reset && rd_entry.valid && (rd_entry.tag == ICACHE_TAG_W'(tag));
    miss_load = !reset && (state == ICACHE_IDLE) && !hit;
    accept    = miss_load && (bus.Imem2proc_response != '0);
    fill      = !reset && (state == ICACHE_WAIT) && (pending_tag != '0) &&
                (bus.Imem2proc_tag == pending_tag);
  end

  assign bus.Icache_valid_out  = hit;
  assign bus.Icache_data_out   = reset ? 64'd0 : rd_entry.data;
  assign bus.proc2Imem_command = miss_load ? BUS_LOAD : BUS_NONE;
  assign bus.proc2Imem_addr    = miss_load ? line_addr(bus.proc2Icache_addr) : '0;

  // Miss controller: one outstanding request, always filled to pending_addr.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ICACHE_IDLE;
      pending_tag  <= '0;
      pending_addr <= '0;
    end else begin
      case (state)
        ICACHE_IDLE: begin
          if (accept) begin
            pending_tag  <= bus.Imem2proc_response;
            pending_addr <= line_addr(bus.proc2Icache_addr);
            state        <= ICACHE_WAIT;
          end
        end
        ICACHE_WAIT: begin
          if (fill) begin
            pending_tag <= '0;
            state       <= ICACHE_IDLE;
          end
        end
        default: state <= ICACHE_IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  // Hit cycles and accepted miss requests, wrapping on overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit)    hit_cnt  <= hit_cnt + 32'd1;
      if (accept) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign bus.icache_hit_cnt  = hit_cnt;
  assign bus.icache_miss_cnt = miss_cnt;
`endif

endmodule
